// File: rtl/psum_buffer.sv
// rtl/psum_buffer.sv - partial-sum scratchpad feeding PE_row, PE write-back, and a valid/ready drain stream
module psum_buffer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int PE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear,
  input  logic        drain,
  input  logic [AW:0] len,
  input  logic [15:0] pe_out,
  output logic [15:0] psum,
  output logic        step,
  output logic        busy,
  output logic        done,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready
);
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DRAIN} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  state_t            state, state_nx;
  logic [15:0]       mem [DEPTH];
  logic              clr_q;
  logic [AW:0]       len_q, ptr, len_clamp;
  logic [AW-1:0]     issue_addr;
  logic [PE_LAT-1:0] pv, pv_nx;
  logic [AW-1:0]     pa [PE_LAT];
  logic              xfer, last;

  assign busy = (state != IDLE);

  always_comb begin
    state_nx  = state;
    len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
    xfer      = dout_valid && dout_ready;
    last      = (ptr == len_q);
    pv_nx     = '0;
    pv_nx[0]  = step;
    for (int i = 1; i < PE_LAT; i++) pv_nx[i] = pv[i-1];
    case (state)
      IDLE: begin
        if (start) begin
          if (len_clamp != '0) state_nx = ISSUE;
        end else if (drain && len_q != '0) begin
          state_nx = DRAIN;
        end
      end
      ISSUE:   if (last) state_nx = FLUSH;
      // Leave once the write that lands at this edge is the final one in flight.
      FLUSH:   if (pv_nx == '0) state_nx = IDLE;
      DRAIN:   if (xfer && last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      clr_q      <= 1'b0;
      len_q      <= '0;
      ptr        <= '0;
      issue_addr <= '0;
      psum       <= '0;
      step       <= 1'b0;
      done       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      pv         <= '0;
    end else begin
      state <= state_nx;
      pv    <= pv_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            clr_q <= clear;
            len_q <= len_clamp;
            ptr   <= ONE;
            if (len_clamp == '0) begin
              done <= 1'b1;
            end else begin
              psum       <= clear ? 16'd0 : mem[0];
              issue_addr <= '0;
              step       <= 1'b1;
            end
          end else if (drain) begin
            if (len_q == '0) begin
              done <= 1'b1;
            end else begin
              dout       <= mem[0];
              dout_valid <= 1'b1;
              ptr        <= ONE;
            end
          end
        end
        ISSUE: begin
          if (!last) begin
            psum       <= clr_q ? 16'd0 : mem[ptr[AW-1:0]];
            issue_addr <= ptr[AW-1:0];
            ptr        <= ptr + ONE;
            step       <= 1'b1;
          end else begin
            step <= 1'b0;
          end
        end
        FLUSH: if (pv_nx == '0) done <= 1'b1;
        DRAIN: begin
          if (xfer) begin
            if (last) begin
              dout_valid <= 1'b0;
              done       <= 1'b1;
            end else begin
              dout <= mem[ptr[AW-1:0]];
              ptr  <= ptr + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // No reset here: a write landing on the reset edge still completes, later ones are cancelled via pv.
  always_ff @(posedge clk) begin
    pa[0] <= issue_addr;
    for (int i = 1; i < PE_LAT; i++) pa[i] <= pa[i-1];
    if (pv[PE_LAT-1]) mem[pa[PE_LAT-1]] <= pe_out;
  end

endmodule

// File: tb/tb_psum_buffer.sv
// tb/tb_psum_buffer.sv - directed and randomized bench for psum_buffer against an array model
module tb_psum_buffer;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int PE_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, clear = 1'b0, drain = 1'b0, dout_ready = 1'b0;
  logic [AW:0] len = '0;
  logic [15:0] pe_out, psum, dout;
  logic [15:0] inc = 16'd1;
  logic [15:0] pe_reg = 16'd0;
  logic        step, busy, done, dout_valid;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] model [DEPTH];
  int          len_model = 0;
  bit          ready_q [$];

  psum_buffer #(.DEPTH(DEPTH), .AW(AW), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .drain(drain),
    .len(len), .pe_out(pe_out), .psum(psum), .step(step), .busy(busy),
    .done(done), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  // PE_row stand-in: adds the pass increment one cycle after presentation.
  always @(posedge clk) pe_reg <= psum + inc;
  assign pe_out = pe_reg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_pass(input bit clr, input int l, input bit poke, input bit with_drain);
    int n;
    n = (l > DEPTH) ? DEPTH : l;
    start = 1'b1; clear = clr; len = (AW+1)'(l); drain = with_drain;
    tick();
    start = 1'b0; drain = 1'b0;
    clear = 1'($urandom); len = (AW+1)'($urandom);
    len_model = n;
    if (n == 0) begin
      check("empty_done", 32'(done), 32'd1);
      check("empty_step", 32'(step), 32'd0);
      check("empty_busy", 32'(busy), 32'd0);
      tick();
      check("empty_done_drop", 32'(done), 32'd0);
      return;
    end
    for (int k = 0; k < n; k++) begin
      check("issue_step", 32'(step), 32'd1);
      check("issue_psum", 32'(psum), 32'(clr ? 16'd0 : model[k]));
      check("issue_busy", 32'(busy), 32'd1);
      check("issue_done", 32'(done), 32'd0);
      check("issue_dvalid", 32'(dout_valid), 32'd0);
      if (poke && k == 1) begin
        start = 1'b1; drain = 1'b1;
      end else begin
        start = 1'b0; drain = 1'b0;
      end
      tick();
    end
    start = 1'b0; drain = 1'b0;
    for (int k = 0; k < PE_LAT; k++) begin
      check("flush_step", 32'(step), 32'd0);
      check("flush_busy", 32'(busy), 32'd1);
      check("flush_done", 32'(done), 32'd0);
      tick();
    end
    check("pass_done", 32'(done), 32'd1);
    check("pass_idle", 32'(busy), 32'd0);
    check("pass_dvalid", 32'(dout_valid), 32'd0);
    for (int i = 0; i < n; i++) model[i] = (clr ? 16'd0 : model[i]) + inc;
  endtask

  task automatic run_drain(input bit rand_ready);
    int idx, cyc;
    bit r;
    idx = 0; cyc = 0;
    drain = 1'b1;
    tick();
    drain = 1'b0;
    while (idx < len_model && cyc < 200) begin
      if (ready_q.size() != 0) r = ready_q.pop_front();
      else r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      dout_ready = r;
      check("drain_valid", 32'(dout_valid), 32'd1);
      check("drain_data", 32'(dout), 32'(model[idx]));
      check("drain_done_early", 32'(done), 32'd0);
      if (r) idx++;
      cyc++;
      tick();
    end
    dout_ready = 1'($urandom);
    if (idx < len_model) check("drain_timeout", 32'(idx), 32'(len_model));
    check("drain_done", 32'(done), 32'd1);
    check("drain_valid_low", 32'(dout_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 16'd0;

    repeat (2) begin
      start = 1'($urandom); drain = 1'($urandom); clear = 1'($urandom);
      len = (AW+1)'($urandom); dout_ready = 1'($urandom);
      tick();
    end
    check("rst_psum", 32'(psum), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dvalid", 32'(dout_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    start = 1'b0; drain = 1'b0; dout_ready = 1'b0; rst = 1'b1;
    tick();

    inc = 16'd1;
    run_pass(1'b1, 4, 1'b0, 1'b0);
    run_drain(1'b0);
    run_pass(1'b0, 4, 1'b0, 1'b0);
    run_drain(1'b0);

    ready_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_drain(1'b0);
    check("bp_pattern_used", 32'(ready_q.size()), 32'd0);

    run_pass(1'b0, 0, 1'b0, 1'b0);

    inc = 16'($urandom);
    run_pass(1'b1, 20, 1'b0, 1'b0);
    run_drain(1'b1);

    inc = 16'($urandom);
    run_pass(1'b0, $urandom_range(2, 16), 1'b1, 1'b0);
    run_drain(1'b1);

    inc = 16'($urandom);
    run_pass(1'($urandom), $urandom_range(1, 16), 1'b0, 1'b1);
    run_drain(1'b1);

    // Reset lands at the edge ending T2: only entry 0's write-back survives.
    inc = 16'd1;
    run_pass(1'b1, 4, 1'b0, 1'b0);
    start = 1'b1; clear = 1'b0; len = (AW+1)'(4);
    tick();
    start = 1'b0;
    check("mid_t1_psum", 32'(psum), 32'(model[0]));
    tick();
    check("mid_t2_psum", 32'(psum), 32'(model[1]));
    rst = 1'b0;
    tick();
    check("mid_rst_psum", 32'(psum), 32'd0);
    check("mid_rst_step", 32'(step), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_dvalid", 32'(dout_valid), 32'd0);
    rst = 1'b1;
    model[0] = model[0] + inc;
    len_model = 0;
    inc = 16'd0;
    run_pass(1'b0, 4, 1'b0, 1'b0);
    run_drain(1'b0);

    for (int it = 0; it < 4; it++) begin
      inc = 16'($urandom);
      run_pass(1'($urandom), $urandom_range(0, 20), 1'($urandom), 1'b0);
      if (len_model != 0) run_drain(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
